// File: rtl/route_line_follower.sv
// Line-follower drive controller with a programmable per-node route table and follow/turn/halt FSM.
// Define LOST_LINE_EN to build in the lost-line timeout (otherwise Lost is tied low).
module route_line_follower #(
  parameter int SENS_W       = 12,
  parameter int PWM_W        = 8,
  parameter int LINE_TH      = 600,
  parameter int NODE_TH      = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int ROUTE_DEPTH  = 32,
  parameter int TURN_MIN     = 256,
  parameter int STRAIGHT_PWM = 10,
  parameter int CORR_FAST    = 100,
  parameter int CORR_SLOW    = 5,
  parameter int TURN_FAST    = 100,
  parameter int TURN_SLOW    = 50,
  parameter int LOST_TO      = 64,
  localparam int ADDR_W      = $clog2(ROUTE_DEPTH)
) (
  input  logic              Clk_50,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [SENS_W-1:0] RightSensor,
  input  logic [SENS_W-1:0] MiddleSensor,
  input  logic [SENS_W-1:0] LeftSensor,
  input  logic              Rt_We,
  input  logic [ADDR_W-1:0] Rt_Addr,
  input  logic [1:0]        Rt_Data,
  output logic [PWM_W-1:0]  R_A_MtrSpeed,
  output logic [PWM_W-1:0]  R_B_MtrSpeed,
  output logic [PWM_W-1:0]  L_A_MtrSpeed,
  output logic [PWM_W-1:0]  L_B_MtrSpeed,
  output logic [ADDR_W:0]   NodeCount,
  output logic              Busy,
  output logic              Stop,
  output logic              Lost
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int TT_W  = $clog2(TURN_MIN + 1);

  localparam logic [SENS_W-1:0] LINE_TH_S = SENS_W'(LINE_TH);
  localparam logic [SENS_W-1:0] NODE_TH_S = SENS_W'(NODE_TH);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [TT_W-1:0]   TURN_MINV = TT_W'(TURN_MIN);
  localparam logic [CNT_W-1:0]  DEPTH_V   = CNT_W'(ROUTE_DEPTH);

  localparam logic [PWM_W-1:0] D_STRAIGHT  = PWM_W'(STRAIGHT_PWM);
  localparam logic [PWM_W-1:0] D_CORR_FAST = PWM_W'(CORR_FAST);
  localparam logic [PWM_W-1:0] D_CORR_SLOW = PWM_W'(CORR_SLOW);
  localparam logic [PWM_W-1:0] D_TURN_FAST = PWM_W'(TURN_FAST);
  localparam logic [PWM_W-1:0] D_TURN_SLOW = PWM_W'(TURN_SLOW);

  localparam logic [1:0] ACT_PASS  = 2'b00;
  localparam logic [1:0] ACT_LEFT  = 2'b01;
  localparam logic [1:0] ACT_RIGHT = 2'b10;
  localparam logic [1:0] ACT_STOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FOLLOW = 2'd1,
    ST_TURN   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        route_r [ROUTE_DEPTH];
  logic [CNT_W-1:0]  node_count_r, node_count_s, node_inc_s;
  logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_s;
  logic [TT_W-1:0]   turn_tmr_r, turn_tmr_s;
  logic              armed_r, armed_s;
  logic              turn_left_r, turn_left_s;
  logic              lost_r, lost_s;
  logic              node_ev_s, lost_hit_s;
  logic [1:0]        action_s;
  logic [PWM_W-1:0]  r_a_r, r_b_r, l_a_r, l_b_r;
  logic [PWM_W-1:0]  r_a_s, r_b_s, l_a_s, l_b_s;
  logic              busy_r, stop_r;

  logic l_hi_s, r_hi_s, cand_s, sides_low_s;
  assign l_hi_s      = LeftSensor > LINE_TH_S;
  assign r_hi_s      = RightSensor > LINE_TH_S;
  assign cand_s      = (LeftSensor > NODE_TH_S) && (RightSensor > NODE_TH_S);
  assign sides_low_s = (LeftSensor < LINE_TH_S) && (RightSensor < LINE_TH_S);
  assign action_s    = route_r[node_count_r[ADDR_W-1:0]];
  assign node_inc_s  = node_count_r + CNT_W'(1);

  // Node detector: debounce only while following; disarm on event, re-arm once both sides drop
  always_comb begin
    deb_cnt_s = '0;
    node_ev_s = 1'b0;
    armed_s   = armed_r;
    if (state_r == ST_FOLLOW && armed_r && cand_s) begin
      if (deb_cnt_r == DEB_LAST) begin
        node_ev_s = 1'b1;
      end else begin
        deb_cnt_s = deb_cnt_r + DEB_W'(1);
      end
    end else begin
      deb_cnt_s = '0;
    end
    if (node_ev_s) begin
      armed_s = 1'b0;
    end else if (sides_low_s) begin
      armed_s = 1'b1;
    end else begin
      armed_s = armed_r;
    end
  end

`ifdef LOST_LINE_EN
  localparam int LOST_W = $clog2(LOST_TO + 1);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TO - 1);
  logic [LOST_W-1:0] lost_cnt_r, lost_cnt_s;
  logic              all_low_s;
  assign all_low_s = (LeftSensor < LINE_TH_S) && (MiddleSensor < LINE_TH_S) &&
                     (RightSensor < LINE_TH_S);

  // Lost-line timer: counts consecutive all-low cycles in FOLLOW only
  always_comb begin
    lost_cnt_s = '0;
    lost_hit_s = 1'b0;
    if (state_r == ST_FOLLOW && all_low_s) begin
      if (lost_cnt_r == LOST_LAST) begin
        lost_hit_s = 1'b1;
      end else begin
        lost_cnt_s = lost_cnt_r + LOST_W'(1);
      end
    end else begin
      lost_cnt_s = '0;
    end
  end

  // Lost-line timer register
  always_ff @(posedge Clk_50) begin
    if (!Rst_n) begin
      lost_cnt_r <= '0;
    end else begin
      lost_cnt_r <= lost_cnt_s;
    end
  end
`else
  logic unused_mid_s;
  assign unused_mid_s = ^MiddleSensor;
  assign lost_hit_s   = 1'b0;
`endif

  // Next-state, node count, turn direction/timer and lost flag
  always_comb begin
    state_s      = state_r;
    node_count_s = node_count_r;
    turn_left_s  = turn_left_r;
    turn_tmr_s   = turn_tmr_r;
    lost_s       = lost_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_s      = ST_FOLLOW;
          node_count_s = '0;
          lost_s       = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_FOLLOW: begin
        if (node_ev_s) begin
          node_count_s = node_inc_s;
          if (action_s == ACT_STOP || node_inc_s == DEPTH_V) begin
            state_s = ST_HALT;
          end else if (action_s == ACT_LEFT || action_s == ACT_RIGHT) begin
            state_s     = ST_TURN;
            turn_left_s = (action_s == ACT_LEFT);
            turn_tmr_s  = '0;
          end else begin
            state_s = ST_FOLLOW;
          end
        end else if (lost_hit_s) begin
          state_s = ST_HALT;
          lost_s  = 1'b1;
        end else begin
          state_s = ST_FOLLOW;
        end
      end
      ST_TURN: begin
        if (turn_tmr_r >= TURN_MINV && sides_low_s) begin
          state_s = ST_FOLLOW;
        end else if (turn_tmr_r < TURN_MINV) begin
          turn_tmr_s = turn_tmr_r + TT_W'(1);
        end else begin
          turn_tmr_s = turn_tmr_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Duty selection for the state being entered, from the current sensor sample
  always_comb begin
    r_a_s = '0;
    r_b_s = '0;
    l_a_s = '0;
    l_b_s = '0;
    case (state_s)
      ST_FOLLOW: begin
        if (l_hi_s && !r_hi_s) begin
          l_a_s = D_CORR_FAST;
          r_a_s = D_CORR_SLOW;
        end else if (r_hi_s && !l_hi_s) begin
          r_a_s = D_CORR_FAST;
          l_a_s = D_CORR_SLOW;
        end else begin
          r_a_s = D_STRAIGHT;
          l_a_s = D_STRAIGHT;
        end
      end
      ST_TURN: begin
        if (turn_left_s) begin
          r_a_s = D_TURN_FAST;
          l_b_s = D_TURN_SLOW;
        end else begin
          l_a_s = D_TURN_FAST;
          r_b_s = D_TURN_SLOW;
        end
      end
      default: begin
        r_a_s = '0;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge Clk_50) begin
    if (!Rst_n) begin
      state_r      <= ST_IDLE;
      node_count_r <= '0;
      deb_cnt_r    <= '0;
      armed_r      <= 1'b1;
      turn_left_r  <= 1'b0;
      turn_tmr_r   <= '0;
      lost_r       <= 1'b0;
      r_a_r        <= '0;
      r_b_r        <= '0;
      l_a_r        <= '0;
      l_b_r        <= '0;
      busy_r       <= 1'b0;
      stop_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      node_count_r <= node_count_s;
      deb_cnt_r    <= deb_cnt_s;
      armed_r      <= armed_s;
      turn_left_r  <= turn_left_s;
      turn_tmr_r   <= turn_tmr_s;
      lost_r       <= lost_s;
      r_a_r        <= r_a_s;
      r_b_r        <= r_b_s;
      l_a_r        <= l_a_s;
      l_b_r        <= l_b_s;
      busy_r       <= (state_s == ST_FOLLOW) || (state_s == ST_TURN);
      stop_r       <= (state_s == ST_HALT);
    end
  end

  // Route table: writable only while idle or halted, never reset
  always_ff @(posedge Clk_50) begin
    if (Rt_We && (state_r == ST_IDLE || state_r == ST_HALT)) begin
      route_r[Rt_Addr] <= Rt_Data;
    end
  end

  assign R_A_MtrSpeed = r_a_r;
  assign R_B_MtrSpeed = r_b_r;
  assign L_A_MtrSpeed = l_a_r;
  assign L_B_MtrSpeed = l_b_r;
  assign NodeCount    = node_count_r;
  assign Busy         = busy_r;
  assign Stop         = stop_r;
  assign Lost         = lost_r;

endmodule

// File: tb/tb_route_line_follower.sv
// Directed testbench for route_line_follower with hand-computed expectations.
module tb_route_line_follower;

  logic        Clk_50 = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [11:0] RightSensor, MiddleSensor, LeftSensor;
  logic        Rt_We;
  logic [4:0]  Rt_Addr;
  logic [1:0]  Rt_Data;
  logic [7:0]  R_A_MtrSpeed, R_B_MtrSpeed, L_A_MtrSpeed, L_B_MtrSpeed;
  logic [5:0]  NodeCount;
  logic        Busy, Stop, Lost;

  int vec_cnt = 0;
  int err_cnt = 0;

  route_line_follower dut (
    .Clk_50(Clk_50), .Rst_n(Rst_n), .Start(Start),
    .RightSensor(RightSensor), .MiddleSensor(MiddleSensor), .LeftSensor(LeftSensor),
    .Rt_We(Rt_We), .Rt_Addr(Rt_Addr), .Rt_Data(Rt_Data),
    .R_A_MtrSpeed(R_A_MtrSpeed), .R_B_MtrSpeed(R_B_MtrSpeed),
    .L_A_MtrSpeed(L_A_MtrSpeed), .L_B_MtrSpeed(L_B_MtrSpeed),
    .NodeCount(NodeCount), .Busy(Busy), .Stop(Stop), .Lost(Lost)
  );

  always #5 Clk_50 = ~Clk_50;

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk_50);
  endtask

  task automatic sides(input int l, input int r);
    LeftSensor  = 12'(l);
    RightSensor = 12'(r);
  endtask

  task automatic wr(input int a, input int d);
    Rt_We = 1'b1; Rt_Addr = 5'(a); Rt_Data = 2'(d);
    tick(1);
    Rt_We = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic duties(input string tag, input int ra, input int rb, input int la, input int lb);
    chk({tag, ".R_A"}, int'(R_A_MtrSpeed), ra);
    chk({tag, ".R_B"}, int'(R_B_MtrSpeed), rb);
    chk({tag, ".L_A"}, int'(L_A_MtrSpeed), la);
    chk({tag, ".L_B"}, int'(L_B_MtrSpeed), lb);
  endtask

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Rt_We = 1'b0; Rt_Addr = 5'd0; Rt_Data = 2'd0;
    sides(1200, 1200); MiddleSensor = 12'd1200;
    tick(2);
    duties("reset", 0, 0, 0, 0);
    chk("reset.Stop", int'(Stop), 0);
    chk("reset.Busy", int'(Busy), 0);
    chk("reset.NodeCount", int'(NodeCount), 0);
    chk("reset.Lost", int'(Lost), 0);
    Rst_n = 1'b1;
    tick(1);

    // Route: node1 PASS, node2 LEFT, node3 STOP, rest PASS
    for (int i = 0; i < 32; i++) wr(i, (i == 1) ? 1 : (i == 2) ? 3 : 0);
    sides(200, 200); MiddleSensor = 12'd200;
    tick(1);
    chk("idle.Busy", int'(Busy), 0);

    pulse_start();
    duties("straight", 10, 0, 10, 0);
    chk("start.Busy", int'(Busy), 1);
    sides(800, 200); tick(1);
    duties("left_hi", 5, 0, 100, 0);
    sides(200, 800); tick(1);
    duties("right_hi", 100, 0, 5, 0);
    sides(600, 600); tick(1);
    duties("at_line_th", 10, 0, 10, 0);
    sides(601, 600); tick(1);
    duties("above_line_th", 5, 0, 100, 0);

    // Debounce: 3 cycles is too short, 4 registers one node, holding counts once
    sides(1200, 1200); tick(3);
    sides(200, 200); tick(1);
    chk("deb3.NodeCount", int'(NodeCount), 0);
    sides(1200, 1200); tick(3);
    chk("deb_pre.NodeCount", int'(NodeCount), 0);
    tick(1);
    chk("deb4.NodeCount", int'(NodeCount), 1);
    chk("pass.Busy", int'(Busy), 1);
    tick(16);
    chk("hold.NodeCount", int'(NodeCount), 1);
    sides(200, 200); tick(1);
    sides(1000, 1000); tick(6);
    chk("at_node_th.NodeCount", int'(NodeCount), 1);
    sides(200, 200); tick(1);

    // Second node -> LEFT turn, minimum turn time
    sides(1200, 1200); tick(4);
    chk("node2.NodeCount", int'(NodeCount), 2);
    duties("turn_left", 100, 0, 0, 50);
    sides(200, 200); tick(100);
    duties("turn_t100", 100, 0, 0, 50);
    tick(156);
    duties("turn_t255", 100, 0, 0, 50);
    chk("turn_t255.Busy", int'(Busy), 1);
    tick(1);
    duties("turn_exit", 10, 0, 10, 0);

    // Writes ignored while running; third node STOP
    wr(2, 0);
    tick(1);
    sides(1200, 1200); tick(4);
    chk("node3.NodeCount", int'(NodeCount), 3);
    chk("node3.Stop", int'(Stop), 1);
    chk("node3.Busy", int'(Busy), 0);
    duties("halt", 0, 0, 0, 0);
    pulse_start();
    chk("restart.NodeCount", int'(NodeCount), 0);
    chk("restart.Stop", int'(Stop), 0);
    chk("restart.Busy", int'(Busy), 1);
    tick(5);
    chk("disarmed.NodeCount", int'(NodeCount), 0);

    // Mid-run reset; write+Start same cycle; table survives reset
    Rst_n = 1'b0; tick(1);
    chk("midreset.Busy", int'(Busy), 0);
    chk("midreset.NodeCount", int'(NodeCount), 0);
    duties("midreset", 0, 0, 0, 0);
    Rst_n = 1'b1; sides(200, 200);
    Rt_We = 1'b1; Rt_Addr = 5'd0; Rt_Data = 2'd2; Start = 1'b1;
    tick(1);
    Rt_We = 1'b0; Start = 1'b0;
    chk("wr_start.Busy", int'(Busy), 1);
    sides(1200, 1200); tick(4);
    duties("turn_right", 0, 50, 100, 0);
    sides(200, 200); tick(257);
    duties("right_exit", 10, 0, 10, 0);
    sides(1200, 1200); tick(4);
    duties("kept_left", 100, 0, 0, 50);

    // Table exhaustion with all-PASS route
    Rst_n = 1'b0; tick(1);
    Rst_n = 1'b1; sides(200, 200);
    for (int i = 0; i < 32; i++) wr(i, 0);
    pulse_start();
    for (int n = 1; n <= 32; n++) begin
      sides(1200, 1200); tick(4);
      if (n == 31) begin
        chk("n31.NodeCount", int'(NodeCount), 31);
        chk("n31.Busy", int'(Busy), 1);
      end
      if (n < 32) begin
        sides(200, 200); tick(1);
      end
    end
    chk("exhaust.NodeCount", int'(NodeCount), 32);
    chk("exhaust.Stop", int'(Stop), 1);
    chk("exhaust.Busy", int'(Busy), 0);

    // Lost-line behaviour
    sides(100, 100); MiddleSensor = 12'd100;
    pulse_start();
`ifdef LOST_LINE_EN
    tick(63);
    chk("lost63.Busy", int'(Busy), 1);
    sides(800, 100); tick(1);
    sides(100, 100); tick(63);
    chk("lost_cleared.Busy", int'(Busy), 1);
    chk("lost_cleared.Lost", int'(Lost), 0);
    tick(1);
    chk("lost64.Stop", int'(Stop), 1);
    chk("lost64.Lost", int'(Lost), 1);
    pulse_start();
    chk("lost_restart.Lost", int'(Lost), 0);
`else
    tick(70);
    chk("all_low.Busy", int'(Busy), 1);
    chk("all_low.Lost", int'(Lost), 0);
    duties("all_low", 10, 0, 10, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
